// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores between the CPU data port and data memory, with load
// hazard detection. Define STORE_BUFFER_FWD_EN to forward loads from an exactly matching store.
`ifndef XLEN
`define XLEN 32
`endif

module store_buffer #(
    parameter int unsigned XLEN  = `XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    input  logic [2:0]             req_funct3,
    output logic                   req_ready,
    output logic [XLEN-1:0]        load_data,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_write_data,
    output logic [2:0]             mem_funct3,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic [XLEN-1:0]        mem_read_data,
    input  logic                   drain_req,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [2:0]      f3_q   [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;

    logic [XLEN:0]    ld_lo, ld_hi;
    logic [DEPTH-1:0] ov;
    logic             hit, fwd_ok, full, drop;
    logic             push, drain, rd, fwd_sel;

    function automatic logic [XLEN:0] size_of(input logic [2:0] f3);
        logic [XLEN:0] s;
        s = '0;
        s[f3[1:0]] = 1'b1;
        return s;
    endfunction

    // Byte ranges use one extra bit so a range ending at the top of memory cannot wrap.
    always_comb begin
        ld_lo = {1'b0, req_addr};
        ld_hi = ld_lo + size_of(req_funct3);
        for (int i = 0; i < DEPTH; i++) begin
            ov[i] = (ld_lo < ({1'b0, addr_q[i]} + size_of(f3_q[i])))
                    && ({1'b0, addr_q[i]} < ld_hi);
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0]   hit_idx;
    logic [XLEN-1:0] fwd_data;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        r = '0;
        case (f3)
            3'b000:  r = XLEN'($signed(d[7:0]));
            3'b001:  r = XLEN'($signed(d[15:0]));
            3'b010:  r = XLEN'($signed(d[31:0]));
            3'b011:  if (XLEN == 64) r = d;
            3'b100:  r = XLEN'(d[7:0]);
            3'b101:  r = XLEN'(d[15:0]);
            3'b110:  if (XLEN == 64) r = XLEN'(d[31:0]);
            default: r = '0;
        endcase
        return r;
    endfunction
`endif

    // Scan from oldest to newest so the last hit is the youngest overlapping store.
    always_comb begin
        hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        hit_idx = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && ov[head_q + PW'(k)]) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                hit_idx = head_q + PW'(k);
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign fwd_ok   = hit && (addr_q[hit_idx] == req_addr)
                      && (f3_q[hit_idx][1:0] >= req_funct3[1:0]);
    assign fwd_data = extend(data_q[hit_idx], req_funct3);
`else
    assign fwd_ok   = 1'b0;
`endif

    assign full = (count_q == CW'(DEPTH));
    assign drop = (XLEN == 32) && (req_funct3 == 3'b011);

    // Stores keep arriving without draining until the buffer is full; a full buffer always
    // drains so loads can never starve the write-back.
    always_comb begin
        req_ready = 1'b0;
        rd        = 1'b0;
        drain     = 1'b0;
        push      = 1'b0;
        fwd_sel   = 1'b0;
        if (!reset) begin
            if (drain_req) begin
                drain = (count_q != '0);
            end else if (req_valid && req_write) begin
                req_ready = 1'b1;
                drain     = full;
                push      = !drop;
            end else if (req_valid) begin
                if (hit) begin
                    req_ready = fwd_ok;
                    fwd_sel   = fwd_ok;
                    drain     = 1'b1;
                end else if (full) begin
                    drain = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    rd        = 1'b1;
                end
            end else begin
                drain = (count_q != '0);
            end
        end
    end

    always_comb begin
        mem_read       = rd;
        mem_write      = drain;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_funct3     = '0;
        if (drain) begin
            mem_addr       = addr_q[head_q];
            mem_write_data = data_q[head_q];
            mem_funct3     = f3_q[head_q];
        end else if (rd) begin
            mem_addr   = req_addr;
            mem_funct3 = req_funct3;
        end
        load_data = '0;
        if (rd) begin
            load_data = mem_read_data;
`ifdef STORE_BUFFER_FWD_EN
        end else if (fwd_sel) begin
            load_data = fwd_data;
`endif
        end
    end

    assign empty = reset || (count_q == '0);
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)  tail_q <= tail_q + PW'(1);
            if (drain) head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= req_addr;
            data_q[tail_q] <= req_wdata;
            f3_q[tail_q]   <= req_funct3;
        end
    end

endmodule
